// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - width derivations and sample extension shared by the accumulator files
package accu_pkg;

  localparam int EXT_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cw_of(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int ow_of(input int dw, input int n);
    return dw + clog2(n);
  endfunction

  // Sign- or zero-extends the low dw bits of d to the full EXT_W bits.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] d, input int dw, input bit sgn);
    logic [EXT_W-1:0] mask;
    logic             sign_bit;
    mask     = (EXT_W'(1) << dw) - EXT_W'(1);
    sign_bit = ((d >> (dw - 1)) & EXT_W'(1)) != '0;
    if (sgn && sign_bit) return d | ~mask;
    return d & mask;
  endfunction

endpackage

// File: rtl/accu_stream_if.sv
// rtl/accu_stream_if.sv - sample input, flush and group-sum output handshake bundle
interface accu_stream_if
  import accu_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 8
);
  localparam int CW = cw_of(N);
  localparam int OW = ow_of(DW, N);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/accu_out_slot.sv
// rtl/accu_out_slot.sv - one-entry output holding register with valid/ready
module accu_out_slot #(
  parameter int OW = 11,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [OW-1:0] i_data,
  input  logic [CW-1:0] i_count,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  output logic [CW-1:0] o_count,
  output logic          o_slot_free
);
  logic          r_valid;
  logic [OW-1:0] r_data;
  logic [CW-1:0] r_count;

  assign o_slot_free = !r_valid || i_ready;

  // The core only loads when the slot is free, so a load may coincide with a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_count <= i_count;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;
endmodule

// File: rtl/accu_stream.sv
// rtl/accu_stream.sv - streaming accumulator emitting one widened sum per group of N samples
module accu_stream
  import accu_pkg::*;
#(
  parameter int DW     = 8,
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input logic          clk,
  input logic          rst,
  accu_stream_if.slave bus
);
  localparam int CW = cw_of(N);
  localparam int OW = ow_of(DW, N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [OW-1:0] r_acc;
  logic [CW-1:0] r_count;

  logic [OW-1:0] w_ext;
  logic [OW-1:0] w_sum;
  logic [CW-1:0] w_count_inc;
  logic          w_slot_free;
  logic          w_ready;
  logic          w_accept;
  logic          w_complete;
  logic          w_flush_go;
  logic          w_load;
  logic          w_out_valid;
  logic [OW-1:0] w_out_data;
  logic [CW-1:0] w_out_count;

  assign w_ext = OW'(ext(EXT_W'(bus.in_data), DW, SIGNED != 0));

  // Only the group-completing sample needs a free output slot.
  assign w_ready     = w_slot_free || (r_count != LAST);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_complete  = w_accept && (r_count == LAST);
  assign w_flush_go  = bus.flush && w_slot_free && ((r_count != '0) || w_accept);
  assign w_load      = w_complete || w_flush_go;
  assign w_sum       = r_acc + (w_accept ? w_ext : '0);
  assign w_count_inc = r_count + (w_accept ? CW'(1) : CW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc   <= w_sum;
      r_count <= w_count_inc;
    end
  end

  accu_out_slot #(
    .OW(OW),
    .CW(CW)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (w_sum),
    .i_count     (w_count_inc),
    .i_ready     (bus.out_ready),
    .o_valid     (w_out_valid),
    .o_data      (w_out_data),
    .o_count     (w_out_count),
    .o_slot_free (w_slot_free)
  );

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_count = w_out_count;
endmodule

// File: tb/tb_accu_stream.sv
// tb/tb_accu_stream.sv - unsigned and signed instances driven in lockstep against a group-list model
module tb_accu_stream;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int OW = 11;

  logic clk;
  logic rst;

  accu_stream_if #(.DW(DW), .N(N)) bu ();
  accu_stream_if #(.DW(DW), .N(N)) bs ();

  accu_stream #(.DW(DW), .N(N), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bu));
  accu_stream #(.DW(DW), .N(N), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: samples of the open group, plus the result sitting in the output slot.
  logic [7:0] q[$];
  bit         m_valid;
  int         m_su;
  int         m_ss;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    bu.in_valid = v; bu.in_data = d; bu.flush = f; bu.out_ready = r;
    bs.in_valid = v; bs.in_data = d; bs.flush = f; bs.out_ready = r;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic f, input logic r);
    bit sf, rdy;
    int su, ss;
    @(negedge clk);
    rst = 1'b0;
    drive(v, d, f, r);
    #1;
    sf  = !m_valid || r;
    rdy = sf || (q.size() != N - 1);
    chk("in_ready_u", 32'(bu.in_ready), 32'(rdy));
    chk("in_ready_s", 32'(bs.in_ready), 32'(rdy));
    chk("out_valid_u", 32'(bu.out_valid), 32'(m_valid));
    chk("out_valid_s", 32'(bs.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data_u", 32'(bu.out_data), 32'(m_su[OW-1:0]));
      chk("out_data_s", 32'(bs.out_data), 32'(m_ss[OW-1:0]));
      chk("out_count_u", 32'(bu.out_count), 32'(m_cnt));
      chk("out_count_s", 32'(bs.out_count), 32'(m_cnt));
    end
    if (v && rdy) q.push_back(d);
    if (q.size() == N || (f && sf && q.size() > 0)) begin
      su = 0;
      ss = 0;
      foreach (q[i]) begin
        su += int'(q[i]);
        ss += int'($signed(q[i]));
      end
      m_valid = 1'b1;
      m_su    = su;
      m_ss    = ss;
      m_cnt   = q.size();
      q.delete();
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_valid_u", 32'(bu.out_valid), 32'd0);
    chk("rst_data_u", 32'(bu.out_data), 32'd0);
    chk("rst_count_u", 32'(bu.out_count), 32'd0);
    chk("rst_valid_s", 32'(bs.out_valid), 32'd0);
    chk("rst_data_s", 32'(bs.out_data), 32'd0);
    q.delete();
    m_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [OW-1:0] u, input logic [OW-1:0] s, input int c);
    #2;
    chk("exp_valid", 32'(bu.out_valid), 32'd1);
    chk("exp_data_u", 32'(bu.out_data), 32'(u));
    chk("exp_data_s", 32'(bs.out_data), 32'(s));
    chk("exp_count", 32'(bu.out_count), 32'(c));
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    m_valid = 1'b0;
    do_reset();

    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    expect_out(11'd36, 11'd36, 8);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    expect_out(11'd2040, 11'h7F8, 8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00, 1'b0, 1'b1);
    expect_out(11'd0, 11'd0, 8);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h80, 1'b0, 1'b1);
    expect_out(11'd1024, 11'h400, 8);
    for (int i = 0; i < 8; i++) cycle(1'b1, (i < 4) ? 8'h7F : 8'hFF, 1'b0, 1'b1);
    expect_out(11'd1528, 11'd504, 8);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h01, 1'b0, 1'b0);
    expect_out(11'd36, 11'd36, 8);
    chk("stall_ready", 32'(bu.in_ready), 32'd0);
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    expect_out(11'd8, 11'd8, 8);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'd10, 1'b0, 1'b1);
    cycle(1'b1, 8'd20, 1'b0, 1'b1);
    cycle(1'b1, 8'd30, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    expect_out(11'd60, 11'd60, 3);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    #2;
    chk("empty_flush", 32'(bu.out_valid), 32'd0);
    cycle(1'b1, 8'd3, 1'b0, 1'b1);
    cycle(1'b1, 8'd4, 1'b0, 1'b1);
    cycle(1'b1, 8'd5, 1'b1, 1'b1);
    expect_out(11'd12, 11'd12, 3);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h01, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h01, 1'b0, 1'b1);
    expect_out(11'd8, 11'd8, 8);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(5))
          0: d = 8'h00;
          1: d = 8'h7F;
          2: d = 8'h80;
          3: d = 8'hFF;
          default: d = 8'($urandom);
        endcase
        cycle($urandom_range(3) != 0, d, $urandom_range(9) == 0, $urandom_range(9) < 7);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
